// File: rtl/fir_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fir_seq_ctrl
// Brief    : Sequencer for a time-multiplexed floating-point FIR. Produces
//            memory addresses/strobes, multiplier and adder issue controls,
//            partial-sum storage strobes and the serial reduction schedule.
//            Valid/ready on input and output, guarded coefficient loading.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module fir_seq_ctrl #(
    parameter int TAPS    = 64,
    parameter int AW      = 8,
    parameter int MUL_LAT = 4,
    parameter int LAT     = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          cload,
    input  logic [AW-1:0] caddr,
    output logic          cload_err,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_waddr,
    output logic [AW-1:0] dmem_raddr,
    output logic          cmem_we,
    output logic [AW-1:0] cmem_addr,
    output logic          mul_v,
    output logic          add_v,
    output logic [1:0]    add_op,
    output logic          add_a_sel,
    output logic [1:0]    add_b_sel,
    output logic          psum_we,
    output logic [3:0]    psum_wa,
    output logic [3:0]    psum_ra,
    output logic          res_we,
    output logic          out_valid,
    input  logic          out_ready
);
    // When TAPS < LAT, zero-passthrough adds keep issuing up to slot LAT-1 so
    // every partial sum is written; c_KN is the number of accumulate slots.
    localparam int c_KN   = (TAPS > LAT) ? TAPS : LAT;
    localparam int c_KW   = $clog2(c_KN + 1);
    localparam int c_CMAX = (MUL_LAT > LAT) ? MUL_LAT : LAT;
    localparam int c_CW   = $clog2(c_CMAX + 1);
    localparam int c_JW   = 5;
    localparam logic [AW-1:0] c_LASTP  = AW'(TAPS - 1);
    localparam logic [AW:0]   c_TAPS_E = (AW + 1)'(TAPS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MUL    = 3'd1,
        S_ACC    = 3'd2,
        S_STORE  = 3'd3,
        S_REDUCE = 3'd4,
        S_HOLD   = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [AW-1:0]      r_wp;
    logic [AW-1:0]      r_p;
    logic [c_KW-1:0]    r_k;
    logic [c_CW-1:0]    r_cnt;
    logic [c_JW-1:0]    r_j;
    logic [MUL_LAT-1:0] r_pipe_v;
    logic [MUL_LAT-1:0] r_pipe_b;
    logic               w_push;
    logic               w_push_b;
    logic [AW:0]        w_pe;
    logic [AW:0]        w_ke;
    logic [AW:0]        w_raddr;

    assign dmem_waddr = r_wp;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Write pointer, latched base pointer and per-phase counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_p   <= '0;
            r_k   <= '0;
            r_cnt <= '0;
            r_j   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_next == S_MUL) begin
                        r_p  <= r_wp;
                        r_wp <= (r_wp == c_LASTP) ? '0 : r_wp + 1'b1;
                        r_k  <= '0;
                    end
                end
                S_MUL: begin
                    r_k   <= r_k + 1'b1;
                    r_cnt <= '0;
                end
                S_ACC: begin
                    r_cnt <= (w_next != S_ACC) ? '0 : r_cnt + 1'b1;
                end
                S_STORE: begin
                    if (w_next != S_STORE) begin
                        r_cnt <= '0;
                        r_j   <= c_JW'(1);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_REDUCE: begin
                    if (r_cnt == c_CW'(LAT - 1)) begin
                        r_cnt <= '0;
                        r_j   <= r_j + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Accumulate-issue delay line: a slot pushed at MUL cycle t pops at t+MUL_LAT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_v <= '0;
            r_pipe_b <= '0;
        end else begin
            for (int i = MUL_LAT - 1; i > 0; i--) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_b[i] <= r_pipe_b[i-1];
            end
            r_pipe_v[0] <= w_push;
            r_pipe_b[0] <= w_push_b;
        end
    end

    // Next-state decode and all control outputs
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        cload_err = 1'b0;
        dmem_we   = 1'b0;
        dmem_raddr = '0;
        cmem_we   = 1'b0;
        cmem_addr = '0;
        mul_v     = 1'b0;
        add_v     = 1'b0;
        add_op    = 2'b00;
        add_a_sel = 1'b0;
        add_b_sel = 2'd0;
        psum_we   = 1'b0;
        psum_wa   = 4'd0;
        psum_ra   = 4'd0;
        res_we    = 1'b0;
        out_valid = 1'b0;
        w_push    = 1'b0;
        w_push_b  = 1'b0;
        w_pe      = {1'b0, r_p};
        w_ke      = '0;
        w_raddr   = '0;
        if (!rst) begin
            // Accumulate issue from the delay line, valid in any state
            if (r_pipe_v[MUL_LAT-1]) begin
                add_v     = 1'b1;
                add_op    = 2'b11;
                add_b_sel = r_pipe_b[MUL_LAT-1] ? 2'd1 : 2'd0;
            end
            case (r_state)
                S_IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        dmem_we = 1'b1;
                        w_next  = S_MUL;
                    end else if (cload && ({1'b0, caddr} < c_TAPS_E)) begin
                        cmem_we   = 1'b1;
                        cmem_addr = caddr;
                    end
                end
                S_MUL: begin
                    w_push   = 1'b1;
                    w_push_b = (r_k >= c_KW'(LAT));
                    if (r_k < c_KW'(TAPS)) begin
                        mul_v     = 1'b1;
                        cmem_addr = AW'(r_k);
                        w_ke      = {1'b0, AW'(r_k)};
                        // Circular read walks backwards from the newest sample
                        w_raddr   = (w_pe >= w_ke) ? (w_pe - w_ke)
                                                   : (w_pe + c_TAPS_E - w_ke);
                        dmem_raddr = w_raddr[AW-1:0];
                    end
                    if (r_k == c_KW'(c_KN - 1)) w_next = S_ACC;
                end
                S_ACC: begin
                    if (r_cnt == c_CW'(MUL_LAT - 1)) w_next = S_STORE;
                end
                S_STORE: begin
                    psum_we = 1'b1;
                    psum_wa = 4'(r_cnt);
                    if (r_cnt == c_CW'(LAT - 1)) w_next = S_REDUCE;
                end
                S_REDUCE: begin
                    // One reduction add every LAT cycles; the final slot captures
                    if (r_cnt == '0) begin
                        if (r_j == c_JW'(LAT)) begin
                            res_we = 1'b1;
                            w_next = S_HOLD;
                        end else begin
                            add_v     = 1'b1;
                            add_a_sel = 1'b1;
                            psum_ra   = 4'(r_j);
                            add_b_sel = (r_j == c_JW'(1)) ? 2'd2 : 2'd1;
                            add_op    = (r_j == c_JW'(LAT - 1)) ? 2'b00 : 2'b11;
                        end
                    end
                end
                S_HOLD: begin
                    out_valid = 1'b1;
                    if (out_ready) w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
            cload_err = cload & ~cmem_we;
        end
    end

endmodule
`default_nettype wire
